transmissor_serial_8bits: RTL and testbench
===========================================

Name: transmissor_serial_8bits

Overview:
- Parallel-to-serial transmitter: the read-out counterpart of the team's 8-bit parallel register.
- Accepts a parallel word through a ready/load handshake, frames it, and shifts it out LSB first on a single serial line.
- Frame: start bit, data bits, optional even-parity bit, stop bit.
- Sits downstream of the register bank; drives a serial link or the matching serial receiver.

Parameters:
WIDTH, 8, data word width in bits
BIT_TICKS, 4, clock cycles per serial bit (>=1)
PARITY_EN, 0, 1 = insert even-parity bit after data; 0 = no parity bit

Ports:
clk  input  1  system clock, all state updates on rising edge
clr  input  1  asynchronous active-high reset (clear)
D  input  WIDTH  parallel word to transmit; sampled only on an accepting edge
load  input  1  request to transmit D
ready  output  1  high when a load will be accepted (IDLE only)
tx  output  1  serial line, idles high, registered
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- One clock (clk); reset clr is asynchronous and active-high. While clr=1: state=IDLE, tx=1, ready=1, busy=0, done=0, shift register=0, bit and tick counters=0. Effective immediately, independent of clk.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: ready=1, busy=0, tx=1.
  - Rising edge with load=1 is an accepting edge: capture D into the shift register, compute parity as the XOR of D, go to START.
  - load=0: stay in IDLE.
- START: tx=0 for BIT_TICKS cycles, then go to DATA.
- DATA: tx = shift register bit 0 for BIT_TICKS cycles per bit; shift right after each bit; WIDTH bits total, LSB first. After the last bit, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx = even-parity bit (total ones in data plus parity is even) for BIT_TICKS cycles, then go to STOP.
- STOP: tx=1 for BIT_TICKS cycles, then go to IDLE.
- Timing:
  - tx takes the start value on the accepting edge E0.
  - Frame length N*BIT_TICKS cycles, N = WIDTH+2+PARITY_EN.
  - At edge E0+N*BIT_TICKS: state=IDLE, busy=0, ready=1, done=1 for exactly one cycle.
- Back-to-back frames: a load held high is accepted on the edge after the return to IDLE. Minimum inter-frame gap is therefore 1 cycle of tx=1 beyond the stop bit.
- busy=1 and ready=0 in every non-IDLE state. load during busy is ignored (not queued).
- D changes after the accepting edge do not affect the frame in flight.
- clr mid-frame aborts immediately. tx returns to 1 with no done pulse; the next load after clr deasserts starts a fresh frame.
- Tick counter counts 0..BIT_TICKS-1 and wraps at each bit boundary. Bit counter counts 0..WIDTH-1. Neither may overflow for any legal parameter value.

Test Plan:
- Reset: clr=1 with load=1, D=8'hFF, for 20 ns -> tx=1, ready=1, busy=0, done=0 throughout; no frame starts after clr falls until load is sampled high.
- Single frame, defaults: D=8'hA5, load pulse for one cycle -> tx over 40 cycles, 4 cycles each, = 0,1,0,1,0,0,1,0,1,1; busy=1 for 40 cycles; done=1 on cycle 40 only; ready=1 again.
- Parity, PARITY_EN=1: D=8'hF0 -> parity bit 0; D=8'hBB -> parity bit 0; D=8'hE5 -> parity bit 1. Each frame is 44 cycles.
- Back-to-back: load held high, D=8'hF0 then 8'hBB -> second start bit begins exactly 1 cycle after the first frame's done; both words are serialized correctly.
- Load during busy: new load with D=8'h00 mid-frame of 8'hA5 -> ignored; 8'hA5 frame unchanged; no extra frame follows.
- Reset mid-frame: clr asserted during data bit 3 of 8'hA5 -> tx=1, busy=0, done never pulses; a subsequent load of 8'h3C transmits cleanly.

Source files
------------

// File: rtl/transmissor_serial_8bits.sv
// Parallel-to-serial transmitter: takes a word on a ready/load handshake and
// sends start, data (LSB first), optional even parity and stop bits on tx.
module transmissor_serial_8bits #(
  parameter int WIDTH     = 8,
  parameter int BIT_TICKS = 4,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] D,
  input  logic             load,
  output logic             ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  // Handshake: a rising clk edge with ready=1 and load=1 accepts D; ready is
  // high only in IDLE, and a load seen while busy is dropped, never queued.

  localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_n;
  logic [TW-1:0]    tick_q, tick_n;
  logic [BW-1:0]    bit_q, bit_n;
  logic [WIDTH-1:0] sh_q, sh_n;
  logic [WIDTH-1:0] sh_next_word;
  logic             par_q, par_n;
  logic             tx_q, tx_n;
  logic             done_q, done_n;
  logic             last_tick;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      tick_q  <= tick_n;
      bit_q   <= bit_n;
      sh_q    <= sh_n;
      par_q   <= par_n;
      tx_q    <= tx_n;
      done_q  <= done_n;
    end
  end

  assign last_tick    = (tick_q == TICK_LAST);
  assign sh_next_word = sh_q >> 1;

  // tx is registered, so each branch computes the value tx carries during
  // the bit that starts on this edge.
  always_comb begin
    state_n = state_q;
    tick_n  = tick_q;
    bit_n   = bit_q;
    sh_n    = sh_q;
    par_n   = par_q;
    tx_n    = tx_q;
    done_n  = 1'b0;
    if (state_q != IDLE) begin
      tick_n = last_tick ? '0 : tick_q + TW'(1);
    end
    case (state_q)
      IDLE: begin
        tx_n = 1'b1;
        if (load) begin
          sh_n    = D;
          par_n   = ^D;
          tick_n  = '0;
          bit_n   = '0;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (last_tick) begin
          tx_n    = sh_q[0];
          state_n = DATA;
        end
      end
      DATA: begin
        if (last_tick) begin
          sh_n = sh_next_word;
          if (bit_q == BIT_LAST) begin
            bit_n = '0;
            if (PARITY_EN != 0) begin
              tx_n    = par_q;
              state_n = PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = STOP;
            end
          end else begin
            bit_n = bit_q + BW'(1);
            tx_n  = sh_next_word[0];
          end
        end
      end
      PARITY: begin
        if (last_tick) begin
          tx_n    = 1'b1;
          state_n = STOP;
        end
      end
      STOP: begin
        if (last_tick) begin
          tx_n    = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign tx    = tx_q;
  assign done  = done_q;

endmodule

// File: tb/tb_transmissor_serial_8bits.sv
// Bench for transmissor_serial_8bits: one instance without parity, one with
// parity; a per-instance monitor reassembles each frame and checks its timing.
module tb_transmissor_serial_8bits;

  localparam int BT = 4;

  logic       clk;
  logic       clr;
  logic [7:0] d_w [2];
  logic [1:0] load_w;
  logic [1:0] ready_w;
  logic [1:0] tx_w;
  logic [1:0] busy_w;
  logic [1:0] done_w;

  int n_checks = 0;
  int n_fail   = 0;

  // Entry layout: bit 11 = frame expected to be aborted by clr, 10:0 = frame
  // bits in line order (bit 0 = start bit), unused upper bits are ones.
  logic [11:0] exp_q0[$];
  logic [11:0] exp_q1[$];

  transmissor_serial_8bits #(.WIDTH(8), .BIT_TICKS(BT), .PARITY_EN(0)) u_dut0 (
    .clk(clk), .clr(clr), .D(d_w[0]), .load(load_w[0]),
    .ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  transmissor_serial_8bits #(.WIDTH(8), .BIT_TICKS(BT), .PARITY_EN(1)) u_dut1 (
    .clk(clk), .clr(clr), .D(d_w[1]), .load(load_w[1]),
    .ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic pb, input logic pen);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (pen) f[9] = pb;
    return f;
  endfunction

  // driver: waits for ready, presents one word, expects acceptance next edge
  task automatic send(input int k, input logic [7:0] d, input logic pb, input logic abort);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready_w[k] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready", 32'(ready_w[k]), 32'd1);
    d_w[k]    = d;
    load_w[k] = 1'b1;
    @(posedge clk);
    if (k == 0) exp_q0.push_back({abort, mk_frame(d, pb, 1'b0)});
    else        exp_q1.push_back({abort, mk_frame(d, pb, 1'b1)});
    #1;
    load_w[k] = 1'b0;
    d_w[k]    = ~d;
  endtask

  // monitor / scoreboard
  logic        in_frame [2];
  int          cyc      [2];
  logic [10:0] bits     [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      in_frame[k] = 1'b0;
      cyc[k]      = 0;
      bits[k]     = '1;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [11:0] e;
      int          nbits;
      nbits = (k == 0) ? 10 : 11;
      if (in_frame[k] && clr) begin
        in_frame[k] = 1'b0;
        check("abort_done", 32'(done_w[k]), 32'd0);
        check("abort_tx", 32'(tx_w[k]), 32'd1);
        if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
          check("abort_unexpected", 32'd1, 32'd0);
        end else begin
          e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check("abort_expected", 32'(e[11]), 32'd1);
        end
      end else if (busy_w[k]) begin
        if (!in_frame[k]) begin
          in_frame[k] = 1'b1;
          cyc[k]      = 0;
          bits[k]     = '1;
        end
        check("done_in_frame", 32'(done_w[k]), 32'd0);
        check("ready_in_frame", 32'(ready_w[k]), 32'd0);
        if (cyc[k] % BT == 1) bits[k][cyc[k] / BT] = tx_w[k];
        cyc[k]++;
      end else if (in_frame[k]) begin
        in_frame[k] = 1'b0;
        check("frame_done", 32'(done_w[k]), 32'd1);
        check("frame_len", 32'(cyc[k]), 32'(nbits * BT));
        check("frame_ready", 32'(ready_w[k]), 32'd1);
        if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
          check("frame_unexpected", 32'(bits[k]), 32'd0);
        end else begin
          e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check("frame_not_aborted", 32'(e[11]), 32'd0);
          check("frame_bits", 32'(bits[k]), 32'(e[10:0]));
        end
      end else begin
        check("idle_done", 32'(done_w[k]), 32'd0);
        check("idle_tx", 32'(tx_w[k]), 32'd1);
      end
    end
  end

  // stimulus
  initial begin
    int guard;
    clr       = 1'b1;
    load_w    = 2'b11;
    d_w[0]    = 8'hFF;
    d_w[1]    = 8'hFF;
    #3;
    check("rst_tx", 32'(tx_w), 32'h3);
    check("rst_ready", 32'(ready_w), 32'h3);
    check("rst_busy", 32'(busy_w), 32'h0);
    check("rst_done", 32'(done_w), 32'h0);
    #17;
    @(negedge clk);
    clr    = 1'b0;
    load_w = 2'b00;
    repeat (5) @(negedge clk);
    check("post_rst_busy", 32'(busy_w), 32'h0);
    check("post_rst_ready", 32'(ready_w), 32'h3);

    // single frame, no parity
    send(0, 8'hA5, 1'b0, 1'b0);

    // parity frame with odd number of ones
    send(1, 8'hE5, 1'b1, 1'b0);

    // back-to-back with load held high; D changes right after acceptance
    @(negedge clk);
    guard = 0;
    while (!ready_w[1] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    d_w[1]    = 8'hF0;
    load_w[1] = 1'b1;
    @(posedge clk);
    exp_q1.push_back({1'b0, mk_frame(8'hF0, 1'b0, 1'b1)});
    #1;
    d_w[1] = 8'hBB;
    exp_q1.push_back({1'b0, mk_frame(8'hBB, 1'b0, 1'b1)});
    repeat (44) @(posedge clk);
    #1;
    check("b2b_done", 32'(done_w[1]), 32'd1);
    check("b2b_idle", 32'(busy_w[1]), 32'd0);
    @(posedge clk);
    #1;
    check("b2b_restart_busy", 32'(busy_w[1]), 32'd1);
    check("b2b_restart_tx", 32'(tx_w[1]), 32'd0);
    load_w[1] = 1'b0;

    // load during busy is ignored
    send(0, 8'hA5, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    d_w[0]    = 8'h00;
    load_w[0] = 1'b1;
    @(negedge clk);
    load_w[0] = 1'b0;

    // reset during data bit 3, then a clean frame
    send(0, 8'hA5, 1'b0, 1'b1);
    repeat (17) @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    check("midrst_tx", 32'(tx_w[0]), 32'd1);
    check("midrst_busy", 32'(busy_w[0]), 32'd0);
    check("midrst_done", 32'(done_w[0]), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2;
    clr = 1'b0;
    send(0, 8'h3C, 1'b0, 1'b0);

    // drain
    guard = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    repeat (60) @(negedge clk);
    check("drain_q0", 32'(exp_q0.size()), 32'd0);
    check("drain_q1", 32'(exp_q1.size()), 32'd0);
    check("final_busy", 32'(busy_w), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
